hbridge_seq: RTL and testbench

Sequencer for the two-leg H-bridge output driver. It generates the driver's `sel2`, `in1` and `in2` controls from a direction request, an enable and a PWM duty word. It inserts a programmable dead time on every direction change so both legs are never driven in overlapping cycles. It sits directly upstream of the driver and downstream of the register/config interface that supplies `en`, `dir` and `duty`.

---
 rtl/hbridge_seq.sv | 149 ++++++++++++++
 tb/tb_hbridge_seq.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/hbridge_seq.sv
// H-bridge sequencer: PWM drive on the leg chosen by sel2, with dead time on direction changes.
// Optional fault handling is compiled in when HDRV_FAULT_EN is defined.
module hbridge_seq #(
    parameter int PWM_W       = 8,
    parameter int DEAD_CYCLES = 4   // legal range 1..255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic [PWM_W-1:0] duty,
`ifdef HDRV_FAULT_EN
    input  logic             fault,
`endif
    output logic             sel2,
    output logic             in1,
    output logic             in2,
    output logic             busy,
    output logic             pwm_wrap
`ifdef HDRV_FAULT_EN
    ,
    output logic             fault_latched
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DEAD  = 2'd2
`ifdef HDRV_FAULT_EN
        ,
        ST_FAULT = 2'd3
`endif
    } state_t;

    localparam logic [7:0]       DEAD_LOAD = 8'(DEAD_CYCLES - 1);
    localparam logic [PWM_W-1:0] CNT_MAX   = {PWM_W{1'b1}};

    state_t           state_reg, state_next;
    logic             sel2_reg, sel2_next;
    logic [7:0]       dead_reg, dead_next;
    logic [PWM_W-1:0] cnt_reg, cnt_next;
    logic [PWM_W-1:0] duty_reg, duty_next;
    logic             drive_next;
    logic             pwm_on_next;

    always_comb begin
        state_next = state_reg;
        sel2_next  = sel2_reg;
        dead_next  = dead_reg;
        cnt_next   = cnt_reg;
        duty_next  = duty_reg;

        case (state_reg)
            ST_IDLE: begin
                if (en) begin
                    if (dir == sel2_reg) begin
                        state_next = ST_DRIVE;
                        cnt_next   = '0;
                        duty_next  = duty;
                    end else begin
                        state_next = ST_DEAD;
                        dead_next  = DEAD_LOAD;
                    end
                end
            end
            ST_DRIVE: begin
                if (!en) begin
                    state_next = ST_IDLE;
                end else if (dir != sel2_reg) begin
                    state_next = ST_DEAD;
                    dead_next  = DEAD_LOAD;
                end else begin
                    cnt_next = cnt_reg + PWM_W'(1);
                    // New duty only takes effect at a period boundary.
                    if (cnt_reg == CNT_MAX) begin
                        duty_next = duty;
                    end
                end
            end
            ST_DEAD: begin
                if (!en) begin
                    state_next = ST_IDLE;
                end else if (dead_reg == 8'd0) begin
                    sel2_next  = dir;
                    state_next = ST_DRIVE;
                    cnt_next   = '0;
                    duty_next  = duty;
                end else begin
                    dead_next = dead_reg - 8'd1;
                end
            end
`ifdef HDRV_FAULT_EN
            ST_FAULT: begin
                if (!en) begin
                    state_next = ST_IDLE;
                end
            end
`endif
            default: begin
                state_next = ST_IDLE;
            end
        endcase

`ifdef HDRV_FAULT_EN
        // Fault overrides every other request and freezes the leg select.
        if (fault) begin
            state_next = ST_FAULT;
            sel2_next  = sel2_reg;
        end
`endif

        drive_next  = (state_next == ST_DRIVE);
        pwm_on_next = (cnt_next < duty_next);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            sel2_reg      <= 1'b0;
            dead_reg      <= '0;
            cnt_reg       <= '0;
            duty_reg      <= '0;
            in1           <= 1'b0;
            in2           <= 1'b0;
            busy          <= 1'b0;
            pwm_wrap      <= 1'b0;
`ifdef HDRV_FAULT_EN
            fault_latched <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            sel2_reg      <= sel2_next;
            dead_reg      <= dead_next;
            cnt_reg       <= cnt_next;
            duty_reg      <= duty_next;
            in1           <= drive_next & pwm_on_next & ~sel2_next;
            in2           <= drive_next & pwm_on_next & sel2_next;
            busy          <= (state_next == ST_DEAD);
            pwm_wrap      <= drive_next & (cnt_next == CNT_MAX);
`ifdef HDRV_FAULT_EN
            fault_latched <= (state_next == ST_FAULT);
`endif
        end
    end

    assign sel2 = sel2_reg;

endmodule

// File: tb/tb_hbridge_seq.sv
// Self-checking bench for hbridge_seq: directed scenarios plus randomized traffic
// compared every cycle against a period/elapsed-time reference model.
module tb_hbridge_seq;
    localparam int PWM_W       = 8;
    localparam int DEAD_CYCLES = 4;
    localparam int P           = 1 << PWM_W;

    logic             clk = 1'b0;
    logic             rst, en, dir;
    logic [PWM_W-1:0] duty;
    logic             sel2, in1, in2, busy, pwm_wrap;
    logic             fault_s;
`ifdef HDRV_FAULT_EN
    logic             fault, fault_latched;
`endif

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    // Reference model: mode 0 idle, 1 drive, 2 dead, 3 fault.
    int m_mode = 0, m_act = 0, m_elapsed = 0, m_pduty = 0, m_dead_left = 0;
    int c_in1, c_in2, c_busy, c_wrap;

    always #5 clk = ~clk;

    hbridge_seq #(.PWM_W(PWM_W), .DEAD_CYCLES(DEAD_CYCLES)) dut (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .duty(duty),
`ifdef HDRV_FAULT_EN
        .fault(fault), .fault_latched(fault_latched),
`endif
        .sel2(sel2), .in1(in1), .in2(in2), .busy(busy), .pwm_wrap(pwm_wrap)
    );

`ifdef HDRV_FAULT_EN
    assign fault_s = fault;
`else
    assign fault_s = 1'b0;
`endif

    task automatic start_drive();
        m_mode    = 1;
        m_elapsed = 0;
        m_pduty   = int'(duty);
    endtask

    task automatic model_edge();
        if (rst) begin
            m_mode = 0; m_act = 0; m_elapsed = 0; m_pduty = 0; m_dead_left = 0;
        end else if (fault_s) begin
            m_mode = 3;
        end else begin
            case (m_mode)
                0: if (en) begin
                    if (int'(dir) == m_act) start_drive();
                    else begin m_mode = 2; m_dead_left = DEAD_CYCLES; end
                end
                1: if (!en) m_mode = 0;
                   else if (int'(dir) != m_act) begin m_mode = 2; m_dead_left = DEAD_CYCLES; end
                   else begin
                       m_elapsed++;
                       if (m_elapsed % P == 0) m_pduty = int'(duty);
                   end
                2: if (!en) m_mode = 0;
                   else begin
                       m_dead_left--;
                       if (m_dead_left == 0) begin m_act = int'(dir); start_drive(); end
                   end
                default: if (!en) m_mode = 0;
            endcase
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_edge();
    end

    // Per-cycle comparison of all outputs against the model.
    initial forever begin
        logic [5:0] got, exp;
        int phase;
        @(negedge clk);
        if (chk_on) begin
            phase = m_elapsed % P;
            exp[5] = (m_mode == 3);
            exp[4] = (m_act == 1);
            exp[3] = (m_mode == 1) && (phase < m_pduty) && (m_act == 0);
            exp[2] = (m_mode == 1) && (phase < m_pduty) && (m_act == 1);
            exp[1] = (m_mode == 2);
            exp[0] = (m_mode == 1) && (phase == P - 1);
`ifdef HDRV_FAULT_EN
            got = {fault_latched, sel2, in1, in2, busy, pwm_wrap};
`else
            got = {1'b0, sel2, in1, in2, busy, pwm_wrap};
`endif
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL cycle_cmp t=%0t {flt,sel2,in1,in2,busy,wrap} got=%b expected=%b", $time, got, exp);
            end
            checks++;
            if (in1 && in2) begin
                errors++;
                $display("FAIL leg_overlap t=%0t in1=%b in2=%b expected not both 1", $time, in1, in2);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic clr();
        c_in1 = 0; c_in2 = 0; c_busy = 0; c_wrap = 0;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            c_in1  += int'(in1);
            c_in2  += int'(in2);
            c_busy += int'(busy);
            c_wrap += int'(pwm_wrap);
            #1;
        end
    endtask

    task automatic rand_phase(input int n, input int en_drop, input int dir_rate);
        for (int i = 0; i < n; i++) begin
            en  = ($urandom_range(0, en_drop - 1) != 0);
            if ($urandom_range(0, dir_rate - 1) == 0) dir = ~dir;
            if ($urandom_range(0, 59) == 0) duty = PWM_W'($urandom);
            rst = ($urandom_range(0, 699) == 0);
`ifdef HDRV_FAULT_EN
            fault = ($urandom_range(0, 399) == 0);
`endif
            step(1);
        end
        rst = 1'b0;
`ifdef HDRV_FAULT_EN
        fault = 1'b0;
`endif
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; dir = 1'b0; duty = '0;
`ifdef HDRV_FAULT_EN
        fault = 1'b0;
`endif
        step(2);
        chk_on = 1'b1;
        step(1);
        check("reset_outputs", int'({sel2, in1, in2, busy, pwm_wrap}), 0);

        // Enable with duty 64 on leg 1.
        rst = 1'b0; en = 1'b1; dir = 1'b0; duty = 8'd64;
        clr(); step(P);
        check("duty64_in1_high", c_in1, 64);
        check("duty64_in2_high", c_in2, 0);
        check("duty64_wraps", c_wrap, 1);

        // Duty change mid-period: current period keeps 64.
        clr(); step(100);
        duty = 8'd200;
        step(P - 100);
        check("mid_change_old_period", c_in1, 64);
        clr(); step(P);
        check("mid_change_new_period", c_in1, 200);

        // Direction change 0->1: dead time then leg 2 from cnt 0.
        dir = 1'b1;
        clr(); step(DEAD_CYCLES);
        check("dead_busy_cycles", c_busy, DEAD_CYCLES);
        check("dead_legs_low", c_in1 + c_in2, 0);
        clr(); step(1);
        check("after_dead_sel2", int'(sel2), 1);
        check("after_dead_in2", c_in2, 1);
        check("after_dead_busy", c_busy, 0);

        // Direction bounces during dead time: completes, sel2 unchanged.
        dir = 1'b0; clr(); step(1);
        dir = 1'b1; step(DEAD_CYCLES - 1);
        check("bounce_busy_cycles", c_busy, DEAD_CYCLES);
        clr(); step(1);
        check("bounce_sel2_kept", int'(sel2), 1);
        check("bounce_in2_resumes", c_in2, 1);

        // Duty 0 then maximum duty.
        en = 1'b0; step(2);
        en = 1'b1; duty = 8'd0;
        clr(); step(P);
        check("duty0_no_pulses", c_in2, 0);
        duty = 8'd255;
        clr(); step(P);
        check("duty255_high", c_in2, 255);

        // Disable during dead time.
        dir = 1'b0; clr(); step(2);
        check("dead_entered", c_busy, 2);
        en = 1'b0; clr(); step(1);
        check("dead_abort_busy", c_busy, 0);
        check("dead_abort_legs", c_in1 + c_in2, 0);
        check("dead_abort_sel2", int'(sel2), 1);

`ifdef HDRV_FAULT_EN
        en = 1'b1; dir = 1'b1; duty = 8'd128; step(10);
        fault = 1'b1; clr(); step(1);
        fault = 1'b0;
        check("fault_latched_set", int'(fault_latched), 1);
        check("fault_legs_low", c_in1 + c_in2, 0);
        step(5);
        check("fault_held_with_en", int'(fault_latched), 1);
        en = 1'b0; step(1);
        check("fault_cleared", int'(fault_latched), 0);
`endif

        // Randomized traffic: short bursts, then long drive stretches for wraps.
        rand_phase(3000, 20, 30);
        rand_phase(3000, 500, 400);

        chk_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
